alu_sequencer: RTL and testbench
================================

# alu_sequencer

Issue controller for the integer ALU in the RV32I minimum core. Accepts one decoded R/I-type arithmetic operation at a time over a valid/ready handshake, decodes funct7 to steer the operation to the base or extra ALU (or flags it illegal), and sequences the ALU handshake. Shifts run iteratively on an internal 1-bit-per-cycle shifter. Returns exactly one result per accepted operation over a second valid/ready handshake. Sits between decode and writeback.

## Interface
- XLEN, 32, operand/result width
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- kill  in  1  synchronous abort; returns to IDLE, no result produced
- op_valid  in  1  operation offered
- op_ready  out  1  sequencer can accept (IDLE only)
- op_funct3  in  3  funct3 of instruction
- op_funct7  in  7  funct7 of instruction (imm[11:5] for I-type)
- op_is_imm  in  1  I-type; operand_b is sign-extended immediate
- op_a  in  XLEN  rs1 value
- op_b  in  XLEN  rs2 value or immediate
- alu_base_enable  out  1  one-cycle start pulse, base ALU (funct7 0x00)
- alu_extra_enable  out  1  one-cycle start pulse, extra ALU (funct7 0x20)
- alu_a, alu_b  out  XLEN  ALU operands, stable throughout ALU_WAIT
- alu_funct3  out  3  ALU function, stable throughout ALU_WAIT
- alu_done  in  1  ALU result valid this cycle
- alu_result  in  XLEN  ALU result
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_data  out  XLEN  result
- res_illegal  out  1  qualifies res_valid; unsupported encoding

## Operation
- States: IDLE, ALU_WAIT, SHIFT, DONE.
- IDLE: op_ready=1. Accept on op_valid. Decode:
  - funct3 001 (SLL) or 101 (SRL/SRA) -> SHIFT; count=op_b[4:0]; arithmetic iff funct3=101 and funct7=0x20. SLL/SRL require funct7=0x00, SRA 0x20, else illegal.
  - other funct3, R-type: funct7=0x00 -> base; funct7=0x20 with funct3=000 (SUB) -> extra; anything else illegal.
  - other funct3, I-type: funct7 ignored, always base.
  - illegal -> DONE with res_illegal=1, res_data=0.
- ALU_WAIT: matching enable high first cycle only; wait for alu_done; capture alu_result -> DONE. alu_done outside ALU_WAIT ignored.
- SHIFT: count!=0 -> shift 1 bit (SRA replicates bit 31), count-1; count==0 -> DONE.
- DONE: res_valid=1, res_data/res_illegal held stable until res_ready; on res_ready -> IDLE.
- kill has priority over every transition; enables and res_valid drop next cycle.
- reset_n low: state IDLE; all outputs 0 except op_ready=1 after release; in-flight op discarded.

## Timing
- Accept in cycle 0 (op_valid & op_ready).
- ALU path: cycle 1 ALU_WAIT with enable pulse; alu_done in cycle n>=1 -> res_valid from cycle n+1.
- Shift path: SHIFT cycles 1..shamt+1; res_valid from cycle shamt+2 (shamt=0 -> cycle 2; shamt=31 -> cycle 33).
- Illegal: res_valid from cycle 1.
- res_valid & res_ready in cycle m -> op_ready in cycle m+1; no same-cycle re-accept; max 1 op in flight.
- alu_base_enable and alu_extra_enable never high together; each high at most 1 cycle per op.

## Structure
- Package alu_pkg: F7_BASE=7'h00, F7_EXTRA=7'h20, funct3 codes (ADD_SUB, SLL, SLT, SLTU, XOR, SRL_SRA, OR, AND), state enum.
- Sub-module alu_serial_shifter: load value/count/direction/arith, step per cycle, done flag.

## Test plan
- R-type ADD, funct7=0x00, a=5, b=7; ALU returns 12 with alu_done in cycle 3 -> alu_base_enable pulse cycle 1 only, res_valid cycle 4, res_data=12.
- R-type SUB, funct7=0x20, funct3=000 -> alu_extra_enable pulse; funct7=0x20 with funct3=100 -> res_illegal=1 in cycle 1, no enable pulse.
- SRA a=0x80000000, shamt=4 -> res_data=0xF8000000, res_valid cycle 6; SRL same -> 0x08000000; SLL shamt=0 -> a unchanged, res_valid cycle 2.
- Backpressure: res_ready low 5 cycles -> res_data stable, op_ready low; op_valid held meanwhile accepted only the cycle after res_ready.
- kill in SHIFT with shamt=31 at cycle 10 -> IDLE cycle 11, no res_valid; next op completes normally.
- reset_n asserted mid-ALU_WAIT -> all outputs 0 immediately; late alu_done after release ignored.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings, state/path enums and funct decode for the ALU issue sequencer.
package alu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [6:0] F7_BASE  = 7'h00;
    localparam logic [6:0] F7_EXTRA = 7'h20;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALU_WAIT,
        ST_SHIFT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        PATH_BASE,
        PATH_EXTRA,
        PATH_SHIFT,
        PATH_ILLEGAL
    } path_e;

    // Operand bundle presented to the ALUs.
    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [2:0]      funct3;
    } alu_req_t;

    // Steer an operation by funct3/funct7; immediates ignore funct7 except on shifts.
    function automatic path_e decode_path(input logic [2:0] f3, input logic [6:0] f7,
                                          input logic is_imm);
        path_e p;
        p = PATH_ILLEGAL;
        if (f3 == F3_SLL) begin
            if (f7 == F7_BASE) p = PATH_SHIFT;
        end else if (f3 == F3_SRL_SRA) begin
            if ((f7 == F7_BASE) || (f7 == F7_EXTRA)) p = PATH_SHIFT;
        end else if (is_imm || (f7 == F7_BASE)) begin
            p = PATH_BASE;
        end else if ((f7 == F7_EXTRA) && (f3 == F3_ADD_SUB)) begin
            p = PATH_EXTRA;
        end
        return p;
    endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle barrel-free shifter: load value/count, step until count hits zero.
module alu_serial_shifter
    import alu_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  logic               step,
    input  logic               dir_left,
    input  logic               arith,
    input  logic [XLEN-1:0]    value_in,
    input  logic [SHAMT_W-1:0] count_in,
    output logic [XLEN-1:0]    value,
    output logic               done_c
);

    logic [XLEN-1:0]    value_q, value_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic               left_q, left_d;
    logic               arith_q, arith_d;

    // Load takes precedence; a step moves one bit and decrements the remaining count.
    always_comb begin
        value_d = value_q;
        count_d = count_q;
        left_d  = left_q;
        arith_d = arith_q;
        if (load) begin
            value_d = value_in;
            count_d = count_in;
            left_d  = dir_left;
            arith_d = arith;
        end else if (step && (count_q != '0)) begin
            if (left_q) value_d = {value_q[XLEN-2:0], 1'b0};
            else        value_d = {arith_q & value_q[XLEN-1], value_q[XLEN-1:1]};
            count_d = count_q - SHAMT_W'(1);
        end
    end

    // Shifter state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
            count_q <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
            left_q  <= left_d;
            arith_q <= arith_d;
        end
    end

    assign value  = value_q;
    assign done_c = (count_q == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Issue controller: accepts one op, runs it on base/extra ALU or the serial shifter, returns one result.
module alu_sequencer
    import alu_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            kill,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [2:0]      op_funct3,
    input  logic [6:0]      op_funct7,
    input  logic            op_is_imm,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            alu_base_enable,
    output logic            alu_extra_enable,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_funct3,
    input  logic            alu_done,
    input  logic [XLEN-1:0] alu_result,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] res_data,
    output logic            res_illegal
);

    state_e          state_q, state_d;
    alu_req_t        alu_req_q, alu_req_d;
    logic            base_en_q, base_en_d;
    logic            extra_en_q, extra_en_d;
    logic            op_ready_q, op_ready_d;
    logic            res_valid_q, res_valid_d;
    logic [XLEN-1:0] res_data_q, res_data_d;
    logic            res_illegal_q, res_illegal_d;
    path_e           path_c;
    logic            sh_load_c, sh_step_c, sh_done_c;
    logic [XLEN-1:0] sh_value;

    alu_serial_shifter u_shifter (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (sh_load_c),
        .step     (sh_step_c),
        .dir_left (op_funct3 == F3_SLL),
        .arith    ((op_funct3 == F3_SRL_SRA) && (op_funct7 == F7_EXTRA)),
        .value_in (op_a),
        .count_in (op_b[SHAMT_W-1:0]),
        .value    (sh_value),
        .done_c   (sh_done_c)
    );

    // Next-state and registered-output logic; kill overrides every transition.
    always_comb begin
        state_d       = state_q;
        alu_req_d     = alu_req_q;
        base_en_d     = 1'b0;
        extra_en_d    = 1'b0;
        res_data_d    = res_data_q;
        res_illegal_d = res_illegal_q;
        sh_load_c     = 1'b0;
        sh_step_c     = 1'b0;
        path_c        = decode_path(op_funct3, op_funct7, op_is_imm);
        case (state_q)
            ST_IDLE: begin
                if (op_valid && op_ready_q) begin
                    case (path_c)
                        PATH_BASE, PATH_EXTRA: begin
                            state_d          = ST_ALU_WAIT;
                            base_en_d        = (path_c == PATH_BASE);
                            extra_en_d       = (path_c == PATH_EXTRA);
                            alu_req_d.a      = op_a;
                            alu_req_d.b      = op_b;
                            alu_req_d.funct3 = op_funct3;
                        end
                        PATH_SHIFT: begin
                            state_d   = ST_SHIFT;
                            sh_load_c = 1'b1;
                        end
                        default: begin
                            state_d       = ST_DONE;
                            res_data_d    = '0;
                            res_illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_ALU_WAIT: begin
                if (alu_done) begin
                    state_d       = ST_DONE;
                    res_data_d    = alu_result;
                    res_illegal_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (sh_done_c) begin
                    state_d       = ST_DONE;
                    res_data_d    = sh_value;
                    res_illegal_d = 1'b0;
                end else begin
                    sh_step_c = 1'b1;
                end
            end
            ST_DONE: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (kill) begin
            state_d       = ST_IDLE;
            alu_req_d     = alu_req_q;
            base_en_d     = 1'b0;
            extra_en_d    = 1'b0;
            res_data_d    = res_data_q;
            res_illegal_d = res_illegal_q;
            sh_load_c     = 1'b0;
            sh_step_c     = 1'b0;
        end
        op_ready_d  = (state_d == ST_IDLE);
        res_valid_d = (state_d == ST_DONE);
    end

    // State and output registers; op_ready rises on the first edge after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            alu_req_q     <= '0;
            base_en_q     <= 1'b0;
            extra_en_q    <= 1'b0;
            op_ready_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_req_q     <= alu_req_d;
            base_en_q     <= base_en_d;
            extra_en_q    <= extra_en_d;
            op_ready_q    <= op_ready_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_illegal_q <= res_illegal_d;
        end
    end

    assign op_ready         = op_ready_q;
    assign alu_base_enable  = base_en_q;
    assign alu_extra_enable = extra_en_q;
    assign alu_a            = alu_req_q.a;
    assign alu_b            = alu_req_q.b;
    assign alu_funct3       = alu_req_q.funct3;
    assign res_valid        = res_valid_q;
    assign res_data         = res_data_q;
    assign res_illegal      = res_illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: timeline model of the issue protocol plus directed literal checks.
module tb_alu_sequencer;

    logic        clk, reset_n, kill, op_valid, op_is_imm, alu_done, res_ready;
    logic [2:0]  op_funct3, alu_funct3;
    logic [6:0]  op_funct7;
    logic [31:0] op_a, op_b, alu_a, alu_b, alu_result, res_data;
    logic        op_ready, alu_base_enable, alu_extra_enable, res_valid, res_illegal;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int t0    = 0;

    alu_sequencer dut (
        .clock            (clk),
        .reset_n          (reset_n),
        .kill             (kill),
        .op_valid         (op_valid),
        .op_ready         (op_ready),
        .op_funct3        (op_funct3),
        .op_funct7        (op_funct7),
        .op_is_imm        (op_is_imm),
        .op_a             (op_a),
        .op_b             (op_b),
        .alu_base_enable  (alu_base_enable),
        .alu_extra_enable (alu_extra_enable),
        .alu_a            (alu_a),
        .alu_b            (alu_b),
        .alu_funct3       (alu_funct3),
        .alu_done         (alu_done),
        .alu_result       (alu_result),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_illegal      (res_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // ---------------- reference model: per-op timeline ----------------
    bit          m_busy, m_wait_alu, m_is_base, m_illegal;
    int          m_acc, m_valid_at;
    logic [31:0] m_data, m_a, m_b;
    logic [2:0]  m_f3;
    logic        exp_ready, exp_valid, exp_base, exp_extra;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_wait_alu = 0; m_is_base = 0; m_illegal = 0;
            m_data = '0; m_a = '0; m_b = '0; m_f3 = '0; m_valid_at = 0; m_acc = 0;
            exp_ready = 0; exp_valid = 0; exp_base = 0; exp_extra = 0;
        end else begin
            if (kill) begin
                m_busy = 0; m_wait_alu = 0;
            end else if (!m_busy) begin
                if (exp_ready && op_valid) begin
                    bit legal, is_shift;
                    int sh;
                    sh       = int'(op_b[4:0]);
                    is_shift = (op_funct3 == 3'd1) || (op_funct3 == 3'd5);
                    if (op_funct3 == 3'd1)      legal = (op_funct7 == 7'h00);
                    else if (op_funct3 == 3'd5) legal = (op_funct7 == 7'h00) || (op_funct7 == 7'h20);
                    else if (op_is_imm)         legal = 1;
                    else legal = (op_funct7 == 7'h00) || (op_funct7 == 7'h20 && op_funct3 == 3'd0);
                    m_busy = 1; m_acc = cyc; m_illegal = 0; m_wait_alu = 0;
                    if (!legal) begin
                        m_valid_at = cyc + 1; m_data = '0; m_illegal = 1;
                    end else if (is_shift) begin
                        m_valid_at = cyc + sh + 2;
                        if (op_funct3 == 3'd1)       m_data = op_a << sh;
                        else if (op_funct7 == 7'h20) m_data = 32'($signed(op_a) >>> sh);
                        else                         m_data = op_a >> sh;
                    end else begin
                        m_wait_alu = 1;
                        m_is_base  = op_is_imm || (op_funct7 == 7'h00);
                        m_a = op_a; m_b = op_b; m_f3 = op_funct3;
                    end
                end
            end else if (exp_valid) begin
                if (res_ready) m_busy = 0;
            end else if (m_wait_alu && alu_done) begin
                m_wait_alu = 0; m_valid_at = cyc + 1; m_data = alu_result;
            end
            cyc++;
            exp_ready = !m_busy;
            exp_valid = m_busy && !m_wait_alu && (cyc >= m_valid_at);
            exp_base  = m_busy && m_wait_alu && m_is_base  && (cyc == m_acc + 1);
            exp_extra = m_busy && m_wait_alu && !m_is_base && (cyc == m_acc + 1);
        end
    end

    // Compare DUT against the model once per cycle, mid-cycle.
    always @(negedge clk) begin
        chk("m_op_ready", 32'(op_ready), 32'(exp_ready));
        chk("m_res_valid", 32'(res_valid), 32'(exp_valid));
        chk("m_base_en", 32'(alu_base_enable), 32'(exp_base));
        chk("m_extra_en", 32'(alu_extra_enable), 32'(exp_extra));
        if (!reset_n || exp_valid) begin
            chk("m_res_data", res_data, reset_n ? m_data : 32'h0);
            chk("m_res_illegal", 32'(res_illegal), reset_n ? 32'(m_illegal) : 32'h0);
        end
        if (!reset_n || (m_busy && m_wait_alu)) begin
            chk("m_alu_a", alu_a, m_a);
            chk("m_alu_b", alu_b, m_b);
            chk("m_alu_f3", 32'(alu_funct3), 32'(m_f3));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                          input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        while (!op_ready && n < 50) begin tick(); n++; end
        if (n >= 50) chk("accept_timeout", 32'(n), 32'(0));
        op_valid = 1; op_funct3 = f3; op_funct7 = f7; op_is_imm = imm; op_a = a; op_b = b;
        t0 = cyc;
        tick();
        op_valid = 0;
    endtask

    task automatic wait_valid(input string nm, input int lat);
        int n;
        n = 0;
        while (!res_valid && n < 100) begin tick(); n++; end
        chk(nm, 32'(cyc - t0), 32'(lat));
    endtask

    initial begin
        reset_n = 0; kill = 0; op_valid = 0; op_funct3 = 0; op_funct7 = 0; op_is_imm = 0;
        op_a = 0; op_b = 0; alu_done = 0; alu_result = 0; res_ready = 1;
        repeat (3) tick();
        chk("rst_op_ready", 32'(op_ready), 32'h0);
        reset_n = 1;
        tick();
        chk("rel_op_ready", 32'(op_ready), 32'h1);

        // ADD 5+7, ALU answers in cycle 3
        accept(3'd0, 7'h00, 0, 32'd5, 32'd7);
        chk("add_base_c1", 32'(alu_base_enable), 32'h1);
        chk("add_alu_b", alu_b, 32'd7);
        tick();
        chk("add_base_c2", 32'(alu_base_enable), 32'h0);
        tick();
        alu_done = 1; alu_result = 32'd12;
        chk("add_valid_c3", 32'(res_valid), 32'h0);
        tick();
        alu_done = 0;
        chk("add_lat", 32'(cyc - t0), 32'd4);
        chk("add_valid_c4", 32'(res_valid), 32'h1);
        chk("add_data", res_data, 32'd12);
        tick();

        // SUB on extra ALU, ALU answers in cycle 1
        accept(3'd0, 7'h20, 0, 32'd10, 32'd3);
        chk("sub_extra", 32'(alu_extra_enable), 32'h1);
        chk("sub_base", 32'(alu_base_enable), 32'h0);
        alu_done = 1; alu_result = 32'd7;
        tick();
        alu_done = 0;
        chk("sub_data", res_data, 32'd7);
        tick();

        // R-type XOR with funct7 0x20 is illegal
        accept(3'd4, 7'h20, 0, 32'hAAAA, 32'h5555);
        chk("ill_valid", 32'(res_valid), 32'h1);
        chk("ill_flag", 32'(res_illegal), 32'h1);
        chk("ill_data", res_data, 32'h0);
        chk("ill_en", 32'({alu_base_enable, alu_extra_enable}), 32'h0);
        tick();

        // ADDI with negative immediate: funct7 ignored
        accept(3'd0, 7'h7F, 1, 32'd100, 32'hFFFF_FFF6);
        chk("addi_base", 32'(alu_base_enable), 32'h1);
        tick();
        alu_done = 1; alu_result = 32'd90;
        tick();
        alu_done = 0;
        chk("addi_data", res_data, 32'd90);
        tick();

        // Shifts
        accept(3'd5, 7'h20, 0, 32'h8000_0000, 32'd4);
        wait_valid("sra_lat", 6);
        chk("sra_data", res_data, 32'hF800_0000);
        tick();
        accept(3'd5, 7'h00, 0, 32'h8000_0000, 32'd4);
        wait_valid("srl_lat", 6);
        chk("srl_data", res_data, 32'h0800_0000);
        tick();
        accept(3'd1, 7'h00, 0, 32'h0000_1234, 32'd0);
        wait_valid("sll0_lat", 2);
        chk("sll0_data", res_data, 32'h0000_1234);
        tick();
        accept(3'd1, 7'h20, 1, 32'h1, 32'd3);
        chk("slli_bad_ill", 32'(res_illegal & res_valid), 32'h1);
        tick();

        // Backpressure: result held 5 cycles, queued op accepted only after release
        res_ready = 0;
        accept(3'd1, 7'h00, 0, 32'h1, 32'd3);
        wait_valid("bp_lat", 5);
        op_valid = 1; op_funct3 = 3'd4; op_funct7 = 7'h00; op_is_imm = 0;
        op_a = 32'hF0; op_b = 32'h0F;
        for (int i = 0; i < 5; i++) begin
            chk("bp_data", res_data, 32'h8);
            chk("bp_op_ready", 32'(op_ready), 32'h0);
            tick();
        end
        res_ready = 1;
        tick();
        chk("bp_ready_after", 32'(op_ready), 32'h1);
        chk("bp_valid_after", 32'(res_valid), 32'h0);
        t0 = cyc;
        tick();
        op_valid = 0;
        chk("bp_next_base", 32'(alu_base_enable), 32'h1);
        alu_done = 1; alu_result = 32'hFF;
        tick();
        alu_done = 0;
        chk("bp_next_data", res_data, 32'hFF);
        tick();

        // kill a long shift at cycle 10
        accept(3'd1, 7'h00, 0, 32'h1, 32'd31);
        while (cyc < t0 + 10) tick();
        kill = 1;
        tick();
        kill = 0;
        chk("kill_ready", 32'(op_ready), 32'h1);
        chk("kill_valid", 32'(res_valid), 32'h0);
        repeat (3) tick();
        chk("kill_no_res", 32'(res_valid), 32'h0);
        accept(3'd5, 7'h00, 0, 32'h10, 32'd2);
        wait_valid("post_kill_lat", 4);
        chk("post_kill_data", res_data, 32'h4);
        tick();

        // reset during ALU_WAIT; late alu_done after release is ignored
        accept(3'd0, 7'h00, 0, 32'd1, 32'd2);
        tick();
        reset_n = 0;
        #1;
        chk("rst_outs", {alu_a[15:0], alu_b[7:0], 5'(alu_funct3), op_ready, res_valid,
                         alu_base_enable}, 32'h0);
        chk("rst_res", res_data | 32'(res_illegal) | 32'(alu_extra_enable), 32'h0);
        repeat (2) tick();
        reset_n = 1;
        alu_done = 1; alu_result = 32'd99;
        tick();
        alu_done = 0;
        chk("rst_late_done", 32'(res_valid), 32'h0);
        chk("rst_ready", 32'(op_ready), 32'h1);
        repeat (2) tick();
        chk("rst_late_done2", 32'(res_valid), 32'h0);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule
